// File: rtl/sap_pkg.sv
// Shared encodings for the SAP control sequencer: opcodes, T-states and control-word bit indices.
// The optional conditional-jump feature (SAP_COND_JUMP_EN) is handled in sap_decode.
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4
  } tstate_e;

  localparam int unsigned CW_W = 14;

  // Drive enables occupy the low bits so they can be masked as one group.
  localparam int unsigned CW_PC_OUT   = 0;
  localparam int unsigned CW_RAM_OUT  = 1;
  localparam int unsigned CW_IR_OUT   = 2;
  localparam int unsigned CW_A_OUT    = 3;
  localparam int unsigned CW_ALU_OUT  = 4;
  localparam int unsigned CW_MAR_LOAD = 5;
  localparam int unsigned CW_IR_LOAD  = 6;
  localparam int unsigned CW_A_LOAD   = 7;
  localparam int unsigned CW_B_LOAD   = 8;
  localparam int unsigned CW_RAM_LOAD = 9;
  localparam int unsigned CW_OUT_LOAD = 10;
  localparam int unsigned CW_PC_LOAD  = 11;
  localparam int unsigned CW_PC_INC   = 12;
  localparam int unsigned CW_ALU_SUB  = 13;

  typedef logic [CW_W-1:0] cw_t;

  localparam cw_t CW_DRIVE_MASK = cw_t'(14'b00_0000_0001_1111);

  function automatic cw_t cw_bit(input int unsigned idx);
    return cw_t'(1) << idx;
  endfunction

endpackage

// File: rtl/sap_decode.sv
// Combinational microcode: (tstate, opcode, flags) -> control word and end-of-instruction flag.
// SAP_COND_JUMP_EN enables JC/JZ; without it opcodes 7 and 8 execute as NOP.
module sap_decode
  import sap_pkg::*;
(
  input  tstate_e         tstate,
  input  logic [3:0]      opcode,
  input  logic            cf,
  input  logic            zf,
  output logic [CW_W-1:0] cw,
  output logic            last_step
);

  logic take_jump;

`ifdef SAP_COND_JUMP_EN
  always_comb begin
    take_jump = 1'b0;
    if (opcode == OP_JMP) begin
      take_jump = 1'b1;
    end else if (opcode == OP_JC) begin
      take_jump = cf;
    end else if (opcode == OP_JZ) begin
      take_jump = zf;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = cf ^ zf;

  always_comb begin
    take_jump = (opcode == OP_JMP);
  end
`endif

  always_comb begin
    cw        = '0;
    last_step = 1'b0;
    case (tstate)
      T1: cw = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
      T2: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD) | cw_bit(CW_PC_INC);
      T3: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
          end
          OP_LDI: begin
            cw        = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LOAD);
            last_step = 1'b1;
          end
          OP_JMP, OP_JC, OP_JZ: begin
            if (take_jump) begin
              cw = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
            end
            last_step = 1'b1;
          end
          OP_OUT: begin
            cw        = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
            last_step = 1'b1;
          end
          // HLT never completes; the top parks the sequencer here.
          OP_HLT: last_step = 1'b0;
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        case (opcode)
          OP_LDA: begin
            cw        = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
            last_step = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD);
          end
          OP_STA: begin
            cw        = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_LOAD);
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T5: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD);
          if (opcode == OP_SUB) begin
            cw = cw | cw_bit(CW_ALU_SUB);
          end
        end
        last_step = 1'b1;
      end
      default: last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/sap_control_seq.sv
// SAP control sequencer top: T-state counter, sticky halt latch, and rst/step_en/halt strobe gating.
// Build option SAP_COND_JUMP_EN (consumed by sap_decode) enables JC/JZ.
module sap_control_seq
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       zf,
  output logic       pc_out,
  output logic       ram_out,
  output logic       ir_out,
  output logic       a_out,
  output logic       alu_out,
  output logic       mar_load,
  output logic       ir_load,
  output logic       a_load,
  output logic       b_load,
  output logic       ram_load,
  output logic       out_load,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       alu_sub,
  output logic       halted,
  output logic [2:0] tstate
);

  tstate_e tstate_q, tstate_d;
  logic    halted_q, halted_d;
  logic    halt_now;
  logic    last_step;
  cw_t     cw_dec;
  cw_t     cw_gated;

  sap_decode u_decode (
    .tstate    (tstate_q),
    .opcode    (opcode),
    .cf        (cf),
    .zf        (zf),
    .cw        (cw_dec),
    .last_step (last_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tstate_q <= T1;
      halted_q <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    tstate_d = tstate_q;
    halted_d = halted_q;
    halt_now = 1'b0;
    if (!halted_q && step_en) begin
      if (tstate_q == T3 && opcode == OP_HLT) begin
        halt_now = 1'b1;
        halted_d = 1'b1;
      end else if (last_step) begin
        tstate_d = T1;
      end else begin
        case (tstate_q)
          T1:      tstate_d = T2;
          T2:      tstate_d = T3;
          T3:      tstate_d = T4;
          T4:      tstate_d = T5;
          default: tstate_d = T1;
        endcase
      end
    end
  end

  // A frozen step keeps its bus driver but must not capture anything.
  always_comb begin
    cw_gated = cw_dec;
    if (rst || halted_q) begin
      cw_gated = '0;
    end else if (!step_en) begin
      cw_gated = cw_dec & CW_DRIVE_MASK;
    end
  end

  assign pc_out   = cw_gated[CW_PC_OUT];
  assign ram_out  = cw_gated[CW_RAM_OUT];
  assign ir_out   = cw_gated[CW_IR_OUT];
  assign a_out    = cw_gated[CW_A_OUT];
  assign alu_out  = cw_gated[CW_ALU_OUT];
  assign mar_load = cw_gated[CW_MAR_LOAD];
  assign ir_load  = cw_gated[CW_IR_LOAD];
  assign a_load   = cw_gated[CW_A_LOAD];
  assign b_load   = cw_gated[CW_B_LOAD];
  assign ram_load = cw_gated[CW_RAM_LOAD];
  assign out_load = cw_gated[CW_OUT_LOAD];
  assign pc_load  = cw_gated[CW_PC_LOAD];
  assign pc_inc   = cw_gated[CW_PC_INC];
  assign alu_sub  = cw_gated[CW_ALU_SUB];

  // Halt is visible in the HLT T3 cycle itself, then held by the latch.
  assign halted = halted_q | (halt_now & ~rst);
  assign tstate = tstate_q;

endmodule
